// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end feeding the IF/ID register: owns the PC, fetches over imem_req/imem_valid,
// obeys freeze and branch redirects. Optional macro PREFETCH_EN adds a one-entry prefetch buffer used in HOLD.
module if_fetch_unit #(
  parameter int ADDRESS_LEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_addr,
  output logic                   imem_req,
  output logic [ADDRESS_LEN-1:0] imem_addr,
  input  logic                   imem_valid,
  input  logic [ADDRESS_LEN-1:0] imem_rdata,
  output logic [ADDRESS_LEN-1:0] pc_out,
  output logic [ADDRESS_LEN-1:0] instruction_out,
  output logic                   if_valid,
  output logic                   dbg_state
);

  // Handshake: a request is live while imem_req is high; imem_addr is held
  // constant until the cycle in which imem_valid is high (possibly the same
  // cycle the request first appears). imem_valid is ignored when imem_req is low.

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  localparam logic [ADDRESS_LEN-1:0] STEP = ADDRESS_LEN'(4);

  state_e                 state_q, state_d;
  logic [ADDRESS_LEN-1:0] pc_q, pc_d;
  logic [ADDRESS_LEN-1:0] target_q, target_d;
  logic                   discard_q, discard_d;
  logic [ADDRESS_LEN-1:0] hold_instr_q, hold_instr_d;
  logic [ADDRESS_LEN-1:0] hold_pc_q, hold_pc_d;
  logic [ADDRESS_LEN-1:0] pc_plus4;

  logic                   req_c;
  logic [ADDRESS_LEN-1:0] addr_c;
  logic [ADDRESS_LEN-1:0] out_pc_c;
  logic [ADDRESS_LEN-1:0] out_instr_c;
  logic                   out_valid_c;

`ifdef PREFETCH_EN
  logic [ADDRESS_LEN-1:0] buf_q, buf_d;
  logic                   buf_full_q, buf_full_d;
  logic                   from_buf_q, from_buf_d;
  logic                   pf_active;
  logic                   pf_hit;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    discard_d    = discard_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    req_c        = 1'b0;
    addr_c       = pc_q;
    out_pc_c     = '0;
    out_instr_c  = '0;
    out_valid_c  = 1'b0;
    pc_plus4     = pc_q + STEP;
`ifdef PREFETCH_EN
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
    from_buf_d   = from_buf_q;
    pf_active    = 1'b0;
    pf_hit       = 1'b0;
`endif

    case (state_q)
      S_FETCH: begin
        req_c       = 1'b1;
        addr_c      = pc_q;
        out_instr_c = imem_rdata;
        out_pc_c    = pc_plus4;
        out_valid_c = imem_valid & ~discard_q & ~branch_taken;
        if (branch_taken) begin
          hold_instr_d = '0;
          hold_pc_d    = '0;
          if (!imem_valid) begin
            // Keep the old address on the bus until its response drains.
            target_d  = branch_addr;
            discard_d = 1'b1;
          end else begin
            pc_d      = branch_addr;
            discard_d = 1'b0;
          end
        end else if (discard_q) begin
          if (imem_valid) begin
            pc_d      = target_q;
            discard_d = 1'b0;
          end
        end else if (imem_valid) begin
          if (!freeze) begin
            pc_d = pc_plus4;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_plus4;
            state_d      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        out_instr_c = hold_instr_q;
        out_pc_c    = hold_pc_q;
        out_valid_c = ~branch_taken;
`ifdef PREFETCH_EN
        // Prefetch the successor of the held word unless it is already buffered
        // or the held word itself came from the buffer.
        pf_active = ~from_buf_q & ~buf_full_q;
        pf_hit    = pf_active & imem_valid;
        req_c     = pf_active;
        addr_c    = hold_pc_q;
`endif
        if (branch_taken) begin
          hold_instr_d = '0;
          hold_pc_d    = '0;
          state_d      = S_FETCH;
`ifdef PREFETCH_EN
          buf_d      = '0;
          buf_full_d = 1'b0;
          from_buf_d = 1'b0;
          if (pf_active && !imem_valid) begin
            pc_d      = hold_pc_q;
            target_d  = branch_addr;
            discard_d = 1'b1;
          end else begin
            pc_d = branch_addr;
          end
`else
          pc_d = branch_addr;
`endif
        end else if (!freeze) begin
          pc_d = pc_plus4;
`ifdef PREFETCH_EN
          if (buf_full_q || pf_hit) begin
            hold_instr_d = buf_full_q ? buf_q : imem_rdata;
            hold_pc_d    = hold_pc_q + STEP;
            from_buf_d   = 1'b1;
            buf_d        = '0;
            buf_full_d   = 1'b0;
          end else begin
            // An in-flight prefetch simply continues as the FETCH request.
            state_d    = S_FETCH;
            from_buf_d = 1'b0;
          end
`else
          state_d = S_FETCH;
`endif
        end
`ifdef PREFETCH_EN
        else if (pf_hit) begin
          buf_d      = imem_rdata;
          buf_full_d = 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      target_q     <= '0;
      discard_q    <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
`ifdef PREFETCH_EN
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      from_buf_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      discard_q    <= discard_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
`ifdef PREFETCH_EN
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      from_buf_q   <= from_buf_d;
`endif
    end
  end

  // Outputs are quiet while reset is held, so a late response is never accepted.
  assign imem_req        = req_c & ~rst;
  assign imem_addr       = rst ? '0 : addr_c;
  assign if_valid        = out_valid_c & ~rst;
  assign pc_out          = rst ? '0 : out_pc_c;
  assign instruction_out = rst ? '0 : out_instr_c;
  assign dbg_state       = state_q;

endmodule
